// File: rtl/idle_wake_ctrl.sv
// idle_wake_ctrl: sequencer for the LoongArch IDLE instruction.
// Stops fetch on a retired IDLE and waits for the pipeline to drain.
// It then parks the core, optionally gating the core clock-enable, until an
// enabled interrupt is pending, and finally redirects fetch to the resume PC.
module idle_wake_ctrl #(
  parameter int PC_W     = 32,
  parameter int WAKE_DLY = 2    // clock-enable settle cycles, legal 1..15
) (
  input  logic            Clk,
  input  logic            Rest,
  input  logic            IdleReq,
  input  logic [PC_W-1:0] IdleNextPc,
  input  logic            IdleFlushEn,
  input  logic            IdleStopEn,
  input  logic            IntPending,
  input  logic            PipeEmpty,
  input  logic            ExtFlush,
  input  logic            PerfClr,
  output logic            FetchStop,
  output logic            PipeFlush,
  output logic [PC_W-1:0] FlushPc,
  output logic            CoreClkEn,
  output logic            IdleState,
  output logic            WakeValid,
  output logic [31:0]     SleepCycles
);

  typedef enum logic [1:0] {RUN, DRAIN, SLEEP, WAKE} state_e;

  // Wake counter counts down to zero, so the restart lands WAKE_DLY cycles
  // after the interrupt was seen.
  localparam logic [3:0] WAKE_LOAD = 4'(WAKE_DLY - 1);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   resume_pc_q, resume_pc_d;
  logic [3:0]        wake_cnt_q, wake_cnt_d;
  logic [31:0]       sleep_cycles_q, sleep_cycles_d;
  logic              fetch_stop_q, fetch_stop_d;
  logic              core_clk_en_q, core_clk_en_d;
  logic              idle_state_q, idle_state_d;

  // Saturating increment for the sleep-cycle performance counter.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Next-state logic and the combinational flush/wake outputs.
  always_comb begin
    state_d     = state_q;
    resume_pc_d = resume_pc_q;
    wake_cnt_d  = wake_cnt_q;
    PipeFlush   = 1'b0;
    FlushPc     = '0;
    WakeValid   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (IdleReq) begin
          resume_pc_d = IdleNextPc;
          state_d     = DRAIN;
          if (IdleFlushEn) begin
            PipeFlush = 1'b1;
            FlushPc   = IdleNextPc;
          end
        end
      end
      DRAIN: begin
        // An external redirect overrides everything; an interrupt skips sleep.
        if (ExtFlush) begin
          state_d = RUN;
        end else if (IntPending) begin
          state_d    = WAKE;
          wake_cnt_d = WAKE_LOAD;
        end else if (PipeEmpty) begin
          state_d = SLEEP;
        end
      end
      SLEEP: begin
        if (ExtFlush) begin
          state_d = RUN;
        end else if (IntPending) begin
          state_d    = WAKE;
          wake_cnt_d = WAKE_LOAD;
        end
      end
      WAKE: begin
        if (ExtFlush) begin
          state_d = RUN;
        end else if (wake_cnt_q == 4'd0) begin
          PipeFlush = 1'b1;
          FlushPc   = resume_pc_q;
          WakeValid = 1'b1;
          state_d   = RUN;
        end else begin
          wake_cnt_d = wake_cnt_q - 4'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Registered decodes of the next state plus the sleep-cycle counter.
  always_comb begin
    fetch_stop_d   = (state_d != RUN);
    idle_state_d   = (state_d == SLEEP);
    core_clk_en_d  = (state_d == SLEEP) ? ~IdleStopEn : 1'b1;
    sleep_cycles_d = sleep_cycles_q;
    if (PerfClr) begin
      sleep_cycles_d = 32'd0;
    end else if (state_q == SLEEP) begin
      sleep_cycles_d = sat_inc32(sleep_cycles_q);
    end
  end

  // State and output registers; reset forces the clock-enable on at once.
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      state_q        <= RUN;
      resume_pc_q    <= '0;
      wake_cnt_q     <= 4'd0;
      sleep_cycles_q <= 32'd0;
      fetch_stop_q   <= 1'b0;
      core_clk_en_q  <= 1'b1;
      idle_state_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      resume_pc_q    <= resume_pc_d;
      wake_cnt_q     <= wake_cnt_d;
      sleep_cycles_q <= sleep_cycles_d;
      fetch_stop_q   <= fetch_stop_d;
      core_clk_en_q  <= core_clk_en_d;
      idle_state_q   <= idle_state_d;
    end
  end

  assign FetchStop   = fetch_stop_q;
  assign CoreClkEn   = core_clk_en_q;
  assign IdleState   = idle_state_q;
  assign SleepCycles = sleep_cycles_q;

endmodule

// File: tb/tb_idle_wake_ctrl.sv
// Bench for idle_wake_ctrl: scenario tasks plus a flush scoreboard.
module tb_idle_wake_ctrl;
  localparam int PC_W     = 32;
  localparam int WAKE_DLY = 2;

  logic            Clk = 1'b0;
  logic            Rest;
  logic            IdleReq, IdleFlushEn, IdleStopEn, IntPending;
  logic            PipeEmpty, ExtFlush, PerfClr;
  logic [PC_W-1:0] IdleNextPc;
  logic            FetchStop, PipeFlush, CoreClkEn, IdleState, WakeValid;
  logic [PC_W-1:0] FlushPc;
  logic [31:0]     SleepCycles;

  typedef struct packed {
    logic [31:0] pc;
    logic        wake;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] exp_sleep   = 32'd0;

  always #5 Clk = ~Clk;

  idle_wake_ctrl #(.PC_W(PC_W), .WAKE_DLY(WAKE_DLY)) dut (
    .Clk(Clk), .Rest(Rest), .IdleReq(IdleReq), .IdleNextPc(IdleNextPc),
    .IdleFlushEn(IdleFlushEn), .IdleStopEn(IdleStopEn), .IntPending(IntPending),
    .PipeEmpty(PipeEmpty), .ExtFlush(ExtFlush), .PerfClr(PerfClr),
    .FetchStop(FetchStop), .PipeFlush(PipeFlush), .FlushPc(FlushPc),
    .CoreClkEn(CoreClkEn), .IdleState(IdleState), .WakeValid(WakeValid),
    .SleepCycles(SleepCycles)
  );

  // Scoreboard: every flush/wake pulse must match the oldest queued expectation.
  always @(negedge Clk) begin
    if (Rest === 1'b1 && (PipeFlush !== 1'b0 || WakeValid !== 1'b0)) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_flush: PipeFlush=%b WakeValid=%b FlushPc=%h, required no flush",
                 PipeFlush, WakeValid, FlushPc);
      end else begin
        mon_e = exp_q.pop_front();
        if (PipeFlush !== 1'b1 || FlushPc !== mon_e.pc || WakeValid !== mon_e.wake) begin
          miscompares++;
          $display("FAIL flush_scoreboard: PipeFlush=%b FlushPc=%h WakeValid=%b, required 1 %h %b",
                   PipeFlush, FlushPc, WakeValid, mon_e.pc, mon_e.wake);
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    vectors++;
    if ({FetchStop, PipeFlush, CoreClkEn, IdleState, WakeValid} !== 5'b00100) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b need 00100",
               {FetchStop, PipeFlush, CoreClkEn, IdleState, WakeValid});
    end
    vectors++;
    if (FlushPc !== 32'h0 || SleepCycles !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_values: FlushPc=%h SleepCycles=%h need 0 0", FlushPc, SleepCycles);
    end
    @(negedge Clk);
    #2;
    Rest = 1'b1;
  endtask

  // Full idle sequence: entry, 3-cycle drain, 10 SLEEP cycles, wake.
  task automatic test_basic(input logic fen, input logic sen, input logic [31:0] pc);
    tick();
    IdleReq = 1'b1; IdleNextPc = pc; IdleFlushEn = fen; IdleStopEn = sen;
    if (fen) exp_q.push_back({pc, 1'b0});
    @(negedge Clk);
    vectors++;
    if ({PipeFlush, FetchStop} !== {fen, 1'b0}) begin
      miscompares++;
      $display("FAIL basic_entry: PipeFlush,FetchStop=%b need %b", {PipeFlush, FetchStop}, {fen, 1'b0});
    end
    tick();
    IdleReq = 1'b0; IdleNextPc = 32'h0;
    @(negedge Clk);
    vectors++;
    if ({FetchStop, IdleState, CoreClkEn, PipeFlush} !== 4'b1010) begin
      miscompares++;
      $display("FAIL basic_drain: got %b need 1010", {FetchStop, IdleState, CoreClkEn, PipeFlush});
    end
    tick();
    tick();
    PipeEmpty = 1'b1;
    @(negedge Clk);
    tick();
    PipeEmpty = 1'b0;
    @(negedge Clk);
    vectors++;
    if ({FetchStop, IdleState, CoreClkEn} !== {2'b11, ~sen} || SleepCycles !== exp_sleep) begin
      miscompares++;
      $display("FAIL basic_sleep: ctrl=%b cnt=%h need %b %h",
               {FetchStop, IdleState, CoreClkEn}, SleepCycles, {2'b11, ~sen}, exp_sleep);
    end
    repeat (9) tick();
    IntPending = 1'b1;
    exp_q.push_back({pc, 1'b1});
    @(negedge Clk);
    vectors++;
    if (SleepCycles !== exp_sleep + 32'd9 || PipeFlush !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_sleep_cnt: cnt=%h flush=%b need %h 0", SleepCycles, PipeFlush, exp_sleep + 32'd9);
    end
    tick();
    IntPending = 1'b0;
    @(negedge Clk);
    vectors++;
    if ({FetchStop, IdleState, CoreClkEn, PipeFlush, WakeValid} !== 5'b10100) begin
      miscompares++;
      $display("FAIL basic_wake: got %b need 10100", {FetchStop, IdleState, CoreClkEn, PipeFlush, WakeValid});
    end
    tick();
    @(negedge Clk);
    vectors++;
    if ({PipeFlush, WakeValid, FetchStop} !== 3'b111 || FlushPc !== pc) begin
      miscompares++;
      $display("FAIL basic_restart: flags=%b pc=%h need 111 %h", {PipeFlush, WakeValid, FetchStop}, FlushPc, pc);
    end
    tick();
    @(negedge Clk);
    vectors++;
    if (FetchStop !== 1'b0 || SleepCycles !== exp_sleep + 32'd10) begin
      miscompares++;
      $display("FAIL basic_resume: FetchStop=%b cnt=%h need 0 %h", FetchStop, SleepCycles, exp_sleep + 32'd10);
    end
    exp_sleep = exp_sleep + 32'd10;
  endtask

  // Interrupt already pending on entry: RUN->DRAIN->WAKE->RUN, no sleep.
  task automatic test_int_with_req(input logic [31:0] pc);
    tick();
    IdleReq = 1'b1; IntPending = 1'b1; IdleNextPc = pc; IdleFlushEn = 1'b0; IdleStopEn = 1'b1;
    exp_q.push_back({pc, 1'b1});
    @(negedge Clk);
    tick();
    IdleReq = 1'b0; IdleNextPc = 32'h0;
    @(negedge Clk);
    vectors++;
    if ({FetchStop, IdleState, PipeFlush} !== 3'b100) begin
      miscompares++;
      $display("FAIL intreq_drain: got %b need 100", {FetchStop, IdleState, PipeFlush});
    end
    tick();
    IntPending = 1'b0;
    @(negedge Clk);
    vectors++;
    if ({FetchStop, IdleState, CoreClkEn, PipeFlush} !== 4'b1010) begin
      miscompares++;
      $display("FAIL intreq_wake: got %b need 1010", {FetchStop, IdleState, CoreClkEn, PipeFlush});
    end
    tick();
    @(negedge Clk);
    vectors++;
    if ({PipeFlush, WakeValid, IdleState} !== 3'b110 || FlushPc !== pc) begin
      miscompares++;
      $display("FAIL intreq_restart: flags=%b pc=%h need 110 %h", {PipeFlush, WakeValid, IdleState}, FlushPc, pc);
    end
    tick();
    @(negedge Clk);
    vectors++;
    if (FetchStop !== 1'b0 || SleepCycles !== exp_sleep) begin
      miscompares++;
      $display("FAIL intreq_resume: FetchStop=%b cnt=%h need 0 %h", FetchStop, SleepCycles, exp_sleep);
    end
  endtask

  // External redirect during DRAIN beats a simultaneous interrupt and empty pipe.
  task automatic test_ext_flush_drain(input logic [31:0] pc);
    tick();
    IdleReq = 1'b1; IdleNextPc = pc; IdleFlushEn = 1'b1;
    exp_q.push_back({pc, 1'b0});
    @(negedge Clk);
    tick();
    IdleReq = 1'b0; IdleNextPc = 32'h0; IdleFlushEn = 1'b0;
    ExtFlush = 1'b1; IntPending = 1'b1; PipeEmpty = 1'b1;
    @(negedge Clk);
    vectors++;
    if ({FetchStop, PipeFlush, WakeValid} !== 3'b100) begin
      miscompares++;
      $display("FAIL extdrain_cycle: got %b need 100", {FetchStop, PipeFlush, WakeValid});
    end
    tick();
    IntPending = 1'b0; PipeEmpty = 1'b0;
    @(negedge Clk);
    vectors++;
    if ({FetchStop, IdleState, CoreClkEn, PipeFlush, WakeValid} !== 5'b00100) begin
      miscompares++;
      $display("FAIL extdrain_run: got %b need 00100", {FetchStop, IdleState, CoreClkEn, PipeFlush, WakeValid});
    end
    tick();
    ExtFlush = 1'b0;
    @(negedge Clk);
    vectors++;
    if ({FetchStop, PipeFlush} !== 2'b00) begin
      miscompares++;
      $display("FAIL extflush_in_run: got %b need 00", {FetchStop, PipeFlush});
    end
  endtask

  task automatic enter_sleep(input logic [31:0] pc, input logic sen);
    tick();
    IdleReq = 1'b1; IdleNextPc = pc; IdleFlushEn = 1'b0; IdleStopEn = sen;
    @(negedge Clk);
    tick();
    IdleReq = 1'b0; IdleNextPc = 32'h0; PipeEmpty = 1'b1;
    @(negedge Clk);
    tick();
    PipeEmpty = 1'b0;
    @(negedge Clk);
    vectors++;
    if ({IdleState, CoreClkEn} !== {1'b1, ~sen}) begin
      miscompares++;
      $display("FAIL enter_sleep: got %b need %b", {IdleState, CoreClkEn}, {1'b1, ~sen});
    end
  endtask

  task automatic test_ext_flush_sleep(input logic [31:0] pc);
    enter_sleep(pc, 1'b1);
    tick();
    tick();
    ExtFlush = 1'b1; IntPending = 1'b1;
    @(negedge Clk);
    tick();
    ExtFlush = 1'b0; IntPending = 1'b0;
    @(negedge Clk);
    vectors++;
    if ({FetchStop, IdleState, CoreClkEn} !== 3'b001 || SleepCycles !== exp_sleep + 32'd3) begin
      miscompares++;
      $display("FAIL extsleep_run: ctrl=%b cnt=%h need 001 %h",
               {FetchStop, IdleState, CoreClkEn}, SleepCycles, exp_sleep + 32'd3);
    end
    exp_sleep = exp_sleep + 32'd3;
    repeat (2) tick();
  endtask

  // Saturation, clear, and a spurious IdleReq that must not move ResumePc.
  task automatic test_saturate(input logic [31:0] pc);
    enter_sleep(pc, 1'b1);
    force dut.sleep_cycles_q = 32'hFFFF_FFFE;
    #1;
    release dut.sleep_cycles_q;
    tick();
    @(negedge Clk);
    vectors++;
    if (SleepCycles !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL sat_reach: got %h need ffffffff", SleepCycles);
    end
    repeat (4) tick();
    @(negedge Clk);
    vectors++;
    if (SleepCycles !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL sat_hold: got %h need ffffffff", SleepCycles);
    end
    tick();
    PerfClr = 1'b1;
    @(negedge Clk);
    tick();
    PerfClr = 1'b0;
    @(negedge Clk);
    vectors++;
    if (SleepCycles !== 32'h0) begin
      miscompares++;
      $display("FAIL perf_clear: got %h need 0", SleepCycles);
    end
    tick();
    IdleReq = 1'b1; IdleNextPc = 32'hDEAD_BEE0; IdleFlushEn = 1'b1;
    @(negedge Clk);
    tick();
    IdleReq = 1'b0; IdleNextPc = 32'h0; IdleFlushEn = 1'b0; IntPending = 1'b1;
    exp_q.push_back({pc, 1'b1});
    @(negedge Clk);
    vectors++;
    if (IdleState !== 1'b1 || SleepCycles !== 32'd2) begin
      miscompares++;
      $display("FAIL spurious_req: IdleState=%b cnt=%h need 1 2", IdleState, SleepCycles);
    end
    tick();
    IntPending = 1'b0;
    tick();
    @(negedge Clk);
    vectors++;
    if ({PipeFlush, WakeValid} !== 2'b11 || FlushPc !== pc) begin
      miscompares++;
      $display("FAIL resume_pc_kept: flags=%b pc=%h need 11 %h", {PipeFlush, WakeValid}, FlushPc, pc);
    end
    tick();
    exp_sleep = 32'd3;
  endtask

  task automatic test_async_reset(input logic [31:0] pc);
    enter_sleep(pc, 1'b1);
    tick();
    #2;
    Rest = 1'b0;
    #1;
    vectors++;
    if ({FetchStop, PipeFlush, CoreClkEn, IdleState, WakeValid} !== 5'b00100 ||
        SleepCycles !== 32'h0 || FlushPc !== 32'h0) begin
      miscompares++;
      $display("FAIL async_reset: ctrl=%b cnt=%h pc=%h need 00100 0 0",
               {FetchStop, PipeFlush, CoreClkEn, IdleState, WakeValid}, SleepCycles, FlushPc);
    end
    exp_sleep = 32'd0;
    @(negedge Clk);
    #2;
    Rest = 1'b1;
    tick();
    @(negedge Clk);
    vectors++;
    if ({FetchStop, CoreClkEn, IdleState} !== 3'b010) begin
      miscompares++;
      $display("FAIL after_reset: got %b need 010", {FetchStop, CoreClkEn, IdleState});
    end
  endtask

  initial begin
    Rest = 1'b0; IdleReq = 1'b0; IdleNextPc = 32'h0; IdleFlushEn = 1'b0;
    IdleStopEn = 1'b0; IntPending = 1'b0; PipeEmpty = 1'b0; ExtFlush = 1'b0;
    PerfClr = 1'b0;
    test_reset();
    test_basic(1'b1, 1'b1, 32'h1C00_0104);
    test_basic(1'b0, 1'b0, 32'h1C00_2208);
    test_int_with_req(32'h1C00_3310);
    test_ext_flush_drain(32'h1C00_4420);
    test_ext_flush_sleep(32'h1C00_5530);
    test_saturate(32'h1C00_6640);
    test_async_reset(32'h1C00_7750);
    repeat (2) tick();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drained: %0d expected flushes never seen, need 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
